video_dram_sched: RTL and testbench

Scheduler that shares the DRAM cycle slots between video fetch and the CPU. It runs a fixed-length DRAM cycle phase counter and opens a per-line video fetch window on each visible line start. It then issues one `video_next` strobe per granted video slot, which advances the video address generator, and one `cpu_next` strobe per granted CPU slot. Within a window video has priority, but every `VID_BURST` consecutive video slots are followed by one slot offered to the CPU, so the CPU is never starved for a whole line.

---
 rtl/video_dram_sched_pkg.sv | 28 ++
 rtl/video_dram_sched_if.sv | 34 +++
 rtl/video_dram_sched_quota.sv | 20 ++
 rtl/video_dram_sched.sv | 119 +++++++++++
 tb/tb_video_dram_sched.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/video_dram_sched_pkg.sv
// Shared types and constants for the video/CPU DRAM slot scheduler.
package video_dram_sched_pkg;

  localparam int unsigned REMAIN_W = 7;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_CPU  = 2'd2
  } owner_e;

  // Per-line video fetch quota in words
  localparam logic [REMAIN_W-1:0] Q_ZX   = 7'd32;
  localparam logic [REMAIN_W-1:0] Q_PHM  = 7'd32;
  localparam logic [REMAIN_W-1:0] Q_P16C = 7'd64;
  localparam logic [REMAIN_W-1:0] Q_AG   = 7'd80;
  localparam logic [REMAIN_W-1:0] Q_TEXT = 7'd80;

  typedef struct packed {
    logic zx;
    logic p_hmclr;
    logic p_16c;
    logic a_16c;
    logic a_hmclr;
    logic a_text;
  } mode_t;

endpackage

// File: rtl/video_dram_sched_if.sv
// Line timing, mode, CPU request and slot-grant signals of the DRAM scheduler.
interface video_dram_sched_if;

  logic       line_start;
  logic       vpix;
  logic       mode_zx;
  logic       mode_p_hmclr;
  logic       mode_p_16c;
  logic       mode_a_16c;
  logic       mode_a_hmclr;
  logic       mode_a_text;
  logic       cpu_req;
  logic       cycle_start;
  logic       video_next;
  logic       cpu_next;
  logic [1:0] owner;
  logic       fetch_busy;
  logic       fetch_ovr;

  modport slave (
    input  line_start, vpix,
    input  mode_zx, mode_p_hmclr, mode_p_16c, mode_a_16c, mode_a_hmclr, mode_a_text,
    input  cpu_req,
    output cycle_start, video_next, cpu_next, owner, fetch_busy, fetch_ovr
  );

  modport master (
    output line_start, vpix,
    output mode_zx, mode_p_hmclr, mode_p_16c, mode_a_16c, mode_a_hmclr, mode_a_text,
    output cpu_req,
    input  cycle_start, video_next, cpu_next, owner, fetch_busy, fetch_ovr
  );

endinterface

// File: rtl/video_dram_sched_quota.sv
// Combinational decode of the active video mode into its per-line word quota.
module video_quota_dec
  import video_dram_sched_pkg::*;
(
  input  mode_t                i_mode,
  output logic [REMAIN_W-1:0]  o_quota_c
);

  // Modes are one-hot; the priority chain only resolves illegal overlaps
  always_comb begin
    o_quota_c = '0;
    if (i_mode.zx)           o_quota_c = Q_ZX;
    else if (i_mode.p_hmclr) o_quota_c = Q_PHM;
    else if (i_mode.p_16c)   o_quota_c = Q_P16C;
    else if (i_mode.a_16c)   o_quota_c = Q_AG;
    else if (i_mode.a_hmclr) o_quota_c = Q_AG;
    else if (i_mode.a_text)  o_quota_c = Q_TEXT;
  end

endmodule

// File: rtl/video_dram_sched.sv
// DRAM slot scheduler: fixed-phase cycle counter, per-line video fetch window,
// video-priority arbitration with a guaranteed CPU slot after every video burst.
module video_dram_sched
  import video_dram_sched_pkg::*;
#(
  parameter int unsigned CYC_LEN   = 4,
  parameter int unsigned VID_BURST = 3
)
(
  input  logic               clk,
  input  logic               rst_n,
  video_dram_sched_if.slave  bus
);

  localparam int unsigned PH_W = (CYC_LEN > 1) ? $clog2(CYC_LEN) : 1;
  localparam int unsigned BC_W = $clog2(VID_BURST + 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CYC_LEN - 1);
  localparam logic [BC_W-1:0] BC_MAX  = BC_W'(VID_BURST);

  logic [PH_W-1:0]     r_ph;
  logic [REMAIN_W-1:0] r_remain;
  logic [BC_W-1:0]     r_bcnt;
  owner_e              r_owner;
  logic                r_cycle_start;
  logic                r_video_next;
  logic                r_cpu_next;
  logic                r_fetch_busy;
  logic                r_fetch_ovr;

  mode_t               w_mode;
  logic [REMAIN_W-1:0] w_quota;
  logic                w_win_open;
  logic                w_slot_edge;
  logic [PH_W-1:0]     w_ph_nxt;
  logic [REMAIN_W-1:0] w_remain_ld;
  logic [BC_W-1:0]     w_bcnt_ld;
  logic [REMAIN_W-1:0] w_remain_nxt;
  logic [BC_W-1:0]     w_bcnt_nxt;
  owner_e              w_owner_nxt;
  logic                w_vid_grant;
  logic                w_cpu_grant;
  logic                w_ovr_nxt;

  assign w_mode = '{zx:      bus.mode_zx,
                    p_hmclr: bus.mode_p_hmclr,
                    p_16c:   bus.mode_p_16c,
                    a_16c:   bus.mode_a_16c,
                    a_hmclr: bus.mode_a_hmclr,
                    a_text:  bus.mode_a_text};

  video_quota_dec u_quota (
    .i_mode    (w_mode),
    .o_quota_c (w_quota)
  );

  // Window load first, then the slot decision sees the freshly loaded quota
  always_comb begin
    w_win_open   = bus.line_start & bus.vpix;
    w_slot_edge  = (r_ph == PH_LAST);
    w_ph_nxt     = w_slot_edge ? '0 : r_ph + PH_W'(1);
    w_remain_ld  = w_win_open ? w_quota : r_remain;
    w_bcnt_ld    = w_win_open ? '0 : r_bcnt;
    w_ovr_nxt    = w_win_open && (r_remain != '0);
    w_remain_nxt = w_remain_ld;
    w_bcnt_nxt   = w_bcnt_ld;
    w_owner_nxt  = r_owner;
    w_vid_grant  = 1'b0;
    w_cpu_grant  = 1'b0;

    if (w_slot_edge) begin
      if ((w_remain_ld != '0) && ((w_bcnt_ld < BC_MAX) || !bus.cpu_req)) begin
        w_vid_grant  = 1'b1;
        w_owner_nxt  = OWN_VID;
        w_remain_nxt = w_remain_ld - REMAIN_W'(1);
        w_bcnt_nxt   = (w_bcnt_ld == BC_MAX) ? w_bcnt_ld : w_bcnt_ld + BC_W'(1);
      end else if (bus.cpu_req) begin
        w_cpu_grant  = 1'b1;
        w_owner_nxt  = OWN_CPU;
        w_bcnt_nxt   = '0;
      end else begin
        w_owner_nxt  = OWN_IDLE;
      end
    end

    if (w_remain_nxt == '0) w_bcnt_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ph          <= '0;
      r_remain      <= '0;
      r_bcnt        <= '0;
      r_owner       <= OWN_IDLE;
      r_cycle_start <= 1'b0;
      r_video_next  <= 1'b0;
      r_cpu_next    <= 1'b0;
      r_fetch_busy  <= 1'b0;
      r_fetch_ovr   <= 1'b0;
    end else begin
      r_ph          <= w_ph_nxt;
      r_remain      <= w_remain_nxt;
      r_bcnt        <= w_bcnt_nxt;
      r_owner       <= w_owner_nxt;
      r_cycle_start <= (w_ph_nxt == '0);
      r_video_next  <= w_vid_grant;
      r_cpu_next    <= w_cpu_grant;
      r_fetch_busy  <= (w_remain_nxt != '0);
      r_fetch_ovr   <= w_ovr_nxt;
    end
  end

  assign bus.cycle_start = r_cycle_start;
  assign bus.video_next  = r_video_next;
  assign bus.cpu_next    = r_cpu_next;
  assign bus.owner       = r_owner;
  assign bus.fetch_busy  = r_fetch_busy;
  assign bus.fetch_ovr   = r_fetch_ovr;

endmodule

// File: tb/tb_video_dram_sched.sv
// Directed self-checking bench for video_dram_sched (CYC_LEN=4, VID_BURST=3).
module tb_video_dram_sched;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  video_dram_sched_if bus ();

  video_dram_sched #(.CYC_LEN(4), .VID_BURST(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_mode(input int m);
    bus.mode_zx      = (m == 0);
    bus.mode_p_hmclr = (m == 1);
    bus.mode_p_16c   = (m == 2);
    bus.mode_a_16c   = (m == 3);
    bus.mode_a_hmclr = (m == 4);
    bus.mode_a_text  = (m == 5);
  endtask

  // One-clock line pulse; returns the strobes seen at the negedge after it
  task automatic pulse_line(input logic v, output logic vn, output logic cn);
    bus.line_start = 1'b1;
    bus.vpix       = v;
    @(negedge clk);
    bus.line_start = 1'b0;
    bus.vpix       = 1'b0;
    vn = bus.video_next;
    cn = bus.cpu_next;
  endtask

  task automatic test_reset();
    logic [6:0] obs;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    obs = {bus.cycle_start, bus.video_next, bus.cpu_next, bus.owner, bus.fetch_busy, bus.fetch_ovr};
    checks++;
    if (obs !== 7'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=%b", obs, 7'b0);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_zx();
    logic vn, cn;
    int vcnt, ccnt, last, gap_bad, cs_bad;
    set_mode(0);
    bus.cpu_req = 1'b0;
    pulse_line(1'b1, vn, cn);
    checks++;
    if (bus.fetch_busy !== 1'b1) begin failures++; $display("FAIL zx_busy_rise got=%b exp=1", bus.fetch_busy); end
    checks++;
    if (bus.fetch_ovr !== 1'b0) begin failures++; $display("FAIL zx_no_ovr got=%b exp=0", bus.fetch_ovr); end
    vcnt = vn ? 1 : 0; ccnt = cn ? 1 : 0; last = vn ? 0 : -1; gap_bad = 0; cs_bad = 0;
    for (int k = 1; k <= 32*4 + 24; k++) begin
      @(negedge clk);
      if (bus.cpu_next) ccnt++;
      if (bus.video_next) begin
        if (last >= 0 && (k - last) != 4) gap_bad++;
        if (!bus.cycle_start) cs_bad++;
        last = k;
        vcnt++;
      end
    end
    checks++;
    if (vcnt != 32) begin failures++; $display("FAIL zx_video_count got=%0d exp=32", vcnt); end
    checks++;
    if (gap_bad != 0) begin failures++; $display("FAIL zx_strobe_spacing bad_gaps=%0d exp=0", gap_bad); end
    checks++;
    if (cs_bad != 0) begin failures++; $display("FAIL zx_strobe_on_phase0 bad=%0d exp=0", cs_bad); end
    checks++;
    if (ccnt != 0) begin failures++; $display("FAIL zx_cpu_count got=%0d exp=0", ccnt); end
    checks++;
    if ({bus.fetch_busy, bus.owner} !== 3'b000) begin
      failures++;
      $display("FAIL zx_end_state busy_owner got=%b exp=000", {bus.fetch_busy, bus.owner});
    end
  endtask

  task automatic test_text_burst();
    logic vn, cn;
    logic is_v [0:127];
    int n, clk_cnt, mism, vtot, c107, own_bad, excl_bad;
    logic exp_v;
    set_mode(5);
    bus.cpu_req = 1'b1;
    pulse_line(1'b1, vn, cn);
    n = 0; own_bad = 0; excl_bad = 0;
    if (vn || cn) begin is_v[n] = vn; n++; end
    clk_cnt = 0;
    while (n < 115 && clk_cnt < 115*4 + 16) begin
      @(negedge clk);
      clk_cnt++;
      if (bus.video_next && bus.cpu_next) excl_bad++;
      if (bus.video_next && bus.owner !== 2'd1) own_bad++;
      if (bus.cpu_next && bus.owner !== 2'd2) own_bad++;
      if (bus.video_next || bus.cpu_next) begin is_v[n] = bus.video_next; n++; end
    end
    bus.cpu_req = 1'b0;
    mism = 0; vtot = 0; c107 = 0;
    for (int i = 0; i < n; i++) begin
      exp_v = (i < 104) ? ((i % 4) != 3) : (i < 106);
      if (is_v[i] !== exp_v) mism++;
      if (is_v[i]) vtot++;
      if (i < 107 && !is_v[i]) c107++;
    end
    checks++;
    if (n != 115) begin failures++; $display("FAIL text_grant_total got=%0d exp=115", n); end
    checks++;
    if (mism != 0) begin failures++; $display("FAIL text_grant_pattern mismatched_slots=%0d exp=0", mism); end
    checks++;
    if (vtot != 80) begin failures++; $display("FAIL text_video_count got=%0d exp=80", vtot); end
    checks++;
    if (c107 != 27) begin failures++; $display("FAIL text_cpu_first107 got=%0d exp=27", c107); end
    checks++;
    if (own_bad != 0 || excl_bad != 0) begin
      failures++;
      $display("FAIL text_owner_excl own_bad=%0d excl_bad=%0d exp=0,0", own_bad, excl_bad);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (bus.owner !== 2'd0) begin failures++; $display("FAIL text_owner_idle got=%0d exp=0", bus.owner); end
  endtask

  task automatic test_overrun();
    logic vn, cn;
    int vcnt, clk_cnt, ovr_cnt;
    set_mode(2);
    bus.cpu_req = 1'b0;
    pulse_line(1'b1, vn, cn);
    checks++;
    if (bus.fetch_ovr !== 1'b0) begin failures++; $display("FAIL ovr_first_window got=%b exp=0", bus.fetch_ovr); end
    vcnt = vn ? 1 : 0; clk_cnt = 0;
    while (vcnt < 54 && clk_cnt < 54*4 + 16) begin
      @(negedge clk);
      clk_cnt++;
      if (bus.video_next) vcnt++;
    end
    checks++;
    if (vcnt != 54) begin failures++; $display("FAIL ovr_pre_count got=%0d exp=54", vcnt); end
    pulse_line(1'b1, vn, cn);
    checks++;
    if ({bus.fetch_ovr, bus.fetch_busy} !== 2'b11) begin
      failures++;
      $display("FAIL ovr_pulse ovr_busy got=%b exp=11", {bus.fetch_ovr, bus.fetch_busy});
    end
    vcnt = vn ? 1 : 0; ovr_cnt = 0;
    for (int k = 0; k < 64*4 + 24; k++) begin
      @(negedge clk);
      if (bus.video_next) vcnt++;
      if (bus.fetch_ovr) ovr_cnt++;
    end
    checks++;
    if (vcnt != 64) begin failures++; $display("FAIL ovr_reload_count got=%0d exp=64", vcnt); end
    checks++;
    if (ovr_cnt != 0) begin failures++; $display("FAIL ovr_pulse_width extra=%0d exp=0", ovr_cnt); end
    checks++;
    if (bus.fetch_busy !== 1'b0) begin failures++; $display("FAIL ovr_busy_end got=%b exp=0", bus.fetch_busy); end
  endtask

  task automatic test_no_vpix();
    logic vn, cn;
    int vcnt, waited, other;
    set_mode(0);
    bus.cpu_req = 1'b0;
    pulse_line(1'b0, vn, cn);
    bus.cpu_req = 1'b1;
    vcnt = vn ? 1 : 0; waited = 0;
    while (!bus.cpu_next && waited < 8) begin
      @(negedge clk);
      waited++;
      if (bus.video_next) vcnt++;
    end
    bus.cpu_req = 1'b0;
    checks++;
    if (!bus.cpu_next || waited > 4) begin
      failures++;
      $display("FAIL novpix_cpu_latency waited=%0d exp<=4 granted=%b", waited, bus.cpu_next);
    end
    checks++;
    if (vcnt != 0 || bus.fetch_busy !== 1'b0) begin
      failures++;
      $display("FAIL novpix_no_video vcnt=%0d busy=%b exp=0,0", vcnt, bus.fetch_busy);
    end
    other = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.video_next || bus.cpu_next) other++;
    end
    checks++;
    if (other != 0) begin failures++; $display("FAIL novpix_quiet strobes=%0d exp=0", other); end
  endtask

  task automatic test_no_mode();
    logic vn, cn;
    int vcnt;
    set_mode(6);
    bus.cpu_req = 1'b0;
    pulse_line(1'b1, vn, cn);
    checks++;
    if (bus.fetch_busy !== 1'b0) begin failures++; $display("FAIL nomode_busy got=%b exp=0", bus.fetch_busy); end
    vcnt = vn ? 1 : 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (bus.video_next) vcnt++;
    end
    checks++;
    if (vcnt != 0) begin failures++; $display("FAIL nomode_video got=%0d exp=0", vcnt); end
  endtask

  task automatic test_reset_mid();
    logic vn, cn;
    logic [6:0] obs;
    int vcnt, clk_cnt, cs_bad;
    set_mode(4);
    bus.cpu_req = 1'b0;
    pulse_line(1'b1, vn, cn);
    vcnt = vn ? 1 : 0; clk_cnt = 0;
    while (vcnt < 60 && clk_cnt < 60*4 + 16) begin
      @(negedge clk);
      clk_cnt++;
      if (bus.video_next) vcnt++;
    end
    checks++;
    if (vcnt != 60 || {bus.fetch_busy, bus.owner} !== 3'b101) begin
      failures++;
      $display("FAIL rstmid_pre vcnt=%0d busy_owner=%b exp=60,101", vcnt, {bus.fetch_busy, bus.owner});
    end
    #2 rst_n = 1'b0;
    #1;
    obs = {bus.cycle_start, bus.video_next, bus.cpu_next, bus.owner, bus.fetch_busy, bus.fetch_ovr};
    checks++;
    if (obs !== 7'b0) begin failures++; $display("FAIL rstmid_async got=%b exp=%b", obs, 7'b0); end
    @(negedge clk);
    rst_n = 1'b1;
    vcnt = 0; cs_bad = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k <= 8 && bus.cycle_start !== ((k % 4) == 0)) cs_bad++;
      if (bus.video_next) vcnt++;
    end
    checks++;
    if (cs_bad != 0) begin failures++; $display("FAIL rstmid_phase_restart bad=%0d exp=0", cs_bad); end
    checks++;
    if (vcnt != 0 || bus.fetch_busy !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_no_video vcnt=%0d busy=%b exp=0,0", vcnt, bus.fetch_busy);
    end
  endtask

  task automatic test_same_edge();
    logic vn, cn;
    int vcnt, waited;
    set_mode(1);
    bus.cpu_req = 1'b0;
    waited = 0;
    @(negedge clk);
    while (!bus.cycle_start && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    repeat (3) @(negedge clk);
    pulse_line(1'b1, vn, cn);
    checks++;
    if (vn !== 1'b1) begin failures++; $display("FAIL same_edge_first_slot got=%b exp=1", vn); end
    vcnt = vn ? 1 : 0;
    for (int k = 0; k < 32*4 + 24; k++) begin
      @(negedge clk);
      if (bus.video_next) vcnt++;
    end
    checks++;
    if (vcnt != 32) begin failures++; $display("FAIL same_edge_total got=%0d exp=32", vcnt); end
    checks++;
    if (bus.fetch_busy !== 1'b0) begin failures++; $display("FAIL same_edge_busy_end got=%b exp=0", bus.fetch_busy); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.line_start = 1'b0;
    bus.vpix = 1'b0;
    bus.cpu_req = 1'b0;
    set_mode(6);
    test_reset();
    test_zx();
    test_text_burst();
    test_overrun();
    test_no_vpix();
    test_no_mode();
    test_reset_mid();
    test_same_edge();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
